// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Upstream producer for instruction_decoder. Holds the PC, issues one read
//   strobe per instruction to instruction memory, presents the returned word on
//   data_out with DOR, and advances the PC by 4 once the consumer acks. A long
//   ack is counted once: after an accepted handshake the block waits for ack to
//   fall before fetching again.
//
// Optional feature (macro IFETCH_REDIRECT_EN): adds redirect_valid/redirect_pc
//   so the PC can be reloaded from any state. Without it the PC is sequential.
//
// Parameters
//   ADDR_WIDTH  word-address width of instruction memory
//   RESET_PC    PC loaded on reset (4-byte aligned)
//
// Ports
//   clk, reset        clock (posedge) / synchronous active-high reset
//   enable            fetch permitted, sampled only in IDLE
//   imem_rd           one-cycle read strobe
//   imem_addr         word address = pc[ADDR_WIDTH+1:2]
//   imem_data         read data, valid with imem_valid
//   imem_valid        one response per strobe, in order
//   DOR               data_out holds a valid instruction
//   ack_from_next     consumer ack (level)
//   data_out          instruction word, stable while DOR=1
//   pc_out            byte address of the word presented / being fetched
//   redirect_valid    (IFETCH_REDIRECT_EN) load PC from redirect_pc
//   redirect_pc       (IFETCH_REDIRECT_EN) new PC
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  imem_rd,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  input  logic                  imem_valid,
  output logic                  DOR,
  input  logic                  ack_from_next,
  output logic [31:0]           data_out,
  output logic [31:0]           pc_out
`ifdef IFETCH_REDIRECT_EN
  ,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_MEM = 3'd2,
    PRESENT  = 3'd3,
    ACK_LOW  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] data_q, data_d;
  logic        dor_q, dor_d;

  // Number of responses still owed by memory for strobes abandoned by a
  // redirect. Memory answers in order, so the next that many responses are
  // dropped. Stays zero when redirect is compiled out.
  logic [2:0]  drop_q, drop_d;
  logic        drop_inc, drop_dec;
  logic        rsp_take;

  logic        redir_v;
  logic [31:0] redir_pc;

`ifdef IFETCH_REDIRECT_EN
  assign redir_v  = redirect_valid;
  assign redir_pc = redirect_pc;
`else
  assign redir_v  = 1'b0;
  assign redir_pc = RESET_PC;
`endif

  assign imem_rd   = (state_q == REQ);
  assign imem_addr = pc_q[ADDR_WIDTH+1:2];
  assign DOR       = dor_q;
  assign data_out  = data_q;
  assign pc_out    = pc_q;

  // A response is ours only if nothing stale is ahead of it and the fetch
  // is not being redirected away in the same cycle.
  assign rsp_take = (state_q == WAIT_MEM) && imem_valid && (drop_q == 3'd0) && !redir_v;

  // A redirect in REQ abandons the strobe issued this cycle; in WAIT_MEM it
  // abandons the pending one unless that response is arriving right now
  // (then it is simply not taken).
  assign drop_inc = redir_v && ((state_q == REQ) ||
                    ((state_q == WAIT_MEM) && !(imem_valid && (drop_q == 3'd0))));
  assign drop_dec = imem_valid && (drop_q != 3'd0);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    dor_d   = dor_q;
    drop_d  = drop_q + 3'(drop_inc) - 3'(drop_dec);

    unique case (state_q)
      IDLE:     if (enable) state_d = REQ;
      REQ:      state_d = WAIT_MEM;
      WAIT_MEM: if (rsp_take) begin
                  data_d  = imem_data;
                  dor_d   = 1'b1;
                  state_d = PRESENT;
                end
      PRESENT:  if (ack_from_next) begin
                  dor_d   = 1'b0;
                  pc_d    = pc_q + 32'd4;
                  state_d = ACK_LOW;
                end
      ACK_LOW:  if (!ack_from_next) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Redirect overrides the sequential PC update; in REQ/WAIT_MEM and an
    // unacked PRESENT it also restarts the fetch at the new PC.
    if (redir_v) begin
      pc_d = redir_pc;
      unique case (state_q)
        REQ, WAIT_MEM: state_d = REQ;
        PRESENT: if (!ack_from_next) begin
                   dor_d   = 1'b0;
                   state_d = REQ;
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      data_q  <= 32'h0;
      dor_q   <= 1'b0;
      drop_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      dor_q   <= dor_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable     [2];
  logic        ack        [2];
  logic        imem_rd    [2];
  logic [9:0]  imem_addr  [2];
  logic [31:0] imem_data  [2];
  logic        imem_valid [2];
  logic        dor        [2];
  logic [31:0] data_out   [2];
  logic [31:0] pc_out     [2];
`ifdef IFETCH_REDIRECT_EN
  logic        redirect_valid [2];
  logic [31:0] redirect_pc    [2];
`endif

  int          lat [2];
  logic [31:0] mem [1024];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.ADDR_WIDTH(10), .RESET_PC(32'h0000_0000)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable[0]),
    .imem_rd(imem_rd[0]), .imem_addr(imem_addr[0]),
    .imem_data(imem_data[0]), .imem_valid(imem_valid[0]),
    .DOR(dor[0]), .ack_from_next(ack[0]),
    .data_out(data_out[0]), .pc_out(pc_out[0])
`ifdef IFETCH_REDIRECT_EN
    , .redirect_valid(redirect_valid[0]), .redirect_pc(redirect_pc[0])
`endif
  );

  instruction_fetch #(.ADDR_WIDTH(10), .RESET_PC(32'hFFFF_FFFC)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable[1]),
    .imem_rd(imem_rd[1]), .imem_addr(imem_addr[1]),
    .imem_data(imem_data[1]), .imem_valid(imem_valid[1]),
    .DOR(dor[1]), .ack_from_next(ack[1]),
    .data_out(data_out[1]), .pc_out(pc_out[1])
`ifdef IFETCH_REDIRECT_EN
    , .redirect_valid(redirect_valid[1]), .redirect_pc(redirect_pc[1])
`endif
  );

  // Memory model per DUT: in-order responses, lat[g] cycles after the strobe.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    int         pend[$];
    logic [9:0] paddr[$];
    always @(posedge clk) begin
      if (reset) begin
        pend.delete();
        paddr.delete();
        imem_valid[g] <= 1'b0;
        imem_data[g]  <= 32'h0;
      end else begin
        if (imem_rd[g]) begin
          pend.push_back(lat[g]);
          paddr.push_back(imem_addr[g]);
        end
        foreach (pend[i]) pend[i] = pend[i] - 1;
        imem_valid[g] <= 1'b0;
        if (pend.size() > 0 && pend[0] <= 0) begin
          imem_valid[g] <= 1'b1;
          imem_data[g]  <= mem[paddr[0]];
          void'(pend.pop_front());
          void'(paddr.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      enable[i] = 1'b0; ack[i] = 1'b0; lat[i] = 1;
`ifdef IFETCH_REDIRECT_EN
      redirect_valid[i] = 1'b0; redirect_pc[i] = 32'h0;
`endif
    end
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_dor(input int d, input int max, output bit got, output int cyc,
                          output int rds, output logic [9:0] addr);
    got = 0; cyc = 0; rds = 0; addr = '0;
    while (!got && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (imem_rd[d]) begin rds++; addr = imem_addr[d]; end
      if (dor[d]) got = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dor[0] !== 1'b0 || dor[1] !== 1'b0) begin
      errors++; $display("FAIL reset_dor: got %b/%b exp 0/0", dor[0], dor[1]); end
    checks++; if (imem_rd[0] !== 1'b0 || imem_rd[1] !== 1'b0) begin
      errors++; $display("FAIL reset_rd: got %b/%b exp 0/0", imem_rd[0], imem_rd[1]); end
    checks++; if (pc_out[0] !== 32'h0) begin
      errors++; $display("FAIL reset_pc0: got %h exp 00000000", pc_out[0]); end
    checks++; if (pc_out[1] !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL reset_pc1: got %h exp fffffffc", pc_out[1]); end
    checks++; if (data_out[0] !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h exp 00000000", data_out[0]); end
  endtask

  task automatic test_basic();
    bit got; int cyc, rds; logic [9:0] a; exp_t e;
    do_reset();
    enable[0] = 1'b1;
    sb.push_back('{pc: 32'h0, data: mem[0]});
    wait_dor(0, 20, got, cyc, rds, a);
    checks++; if (!got || cyc != 3) begin
      errors++; $display("FAIL basic_latency: got %0d cycles (seen=%0b) exp 3", cyc, got); end
    e = sb.pop_front();
    checks++; if (data_out[0] !== e.data) begin
      errors++; $display("FAIL basic_data: got %h exp %h", data_out[0], e.data); end
    checks++; if (pc_out[0] !== e.pc) begin
      errors++; $display("FAIL basic_pc: got %h exp %h", pc_out[0], e.pc); end
    checks++; if (rds != 1 || a !== 10'd0) begin
      errors++; $display("FAIL basic_strobe: got %0d strobes addr %h exp 1 addr 000", rds, a); end
    ack[0] = 1'b1;
    @(negedge clk);
    checks++; if (dor[0] !== 1'b0 || pc_out[0] !== 32'h4) begin
      errors++; $display("FAIL basic_ack: got dor=%b pc=%h exp dor=0 pc=00000004", dor[0], pc_out[0]); end
    ack[0] = 1'b0;
    got = 0; a = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (imem_rd[0]) begin got = 1; a = imem_addr[0]; end
    end
    checks++; if (!got || a !== 10'd1) begin
      errors++; $display("FAIL basic_next_addr: got %h (seen=%0b) exp 001", a, got); end
    enable[0] = 1'b0;
  endtask

  // Ack raised before DOR and held: accepted the cycle DOR rises, counted once.
  task automatic test_ack_held();
    bit got, bad; int cyc, rds; logic [9:0] a; exp_t e;
    do_reset();
    enable[0] = 1'b1;
    sb.push_back('{pc: 32'h0, data: mem[0]});
    @(negedge clk);
    ack[0] = 1'b1;
    wait_dor(0, 20, got, cyc, rds, a);
    e = sb.pop_front();
    checks++; if (!got || data_out[0] !== e.data) begin
      errors++; $display("FAIL held_data: got %h (seen=%0b) exp %h", data_out[0], got, e.data); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dor[0] !== 1'b0 || pc_out[0] !== 32'h4 || imem_rd[0] !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin
      errors++; $display("FAIL held_single_advance: got dor=%b pc=%h exp dor=0 pc=00000004", dor[0], pc_out[0]); end
    ack[0] = 1'b0;
    enable[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Slow memory, stalled consumer, enable dropped mid-fetch.
  task automatic test_slow_mem();
    bit got, stable; int cyc, rds, total; logic [9:0] a; exp_t e;
    do_reset();
    lat[0] = 4;
    enable[0] = 1'b1;
    sb.push_back('{pc: 32'h0, data: mem[0]});
    @(negedge clk);
    total = imem_rd[0] ? 1 : 0;
    enable[0] = 1'b0;
    wait_dor(0, 30, got, cyc, rds, a);
    total += rds;
    e = sb.pop_front();
    checks++; if (!got || data_out[0] !== e.data) begin
      errors++; $display("FAIL slow_data: got %h (seen=%0b) exp %h", data_out[0], got, e.data); end
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_rd[0]) total++;
      if (dor[0] !== 1'b1 || data_out[0] !== e.data || pc_out[0] !== e.pc) stable = 0;
    end
    checks++; if (!stable) begin
      errors++; $display("FAIL slow_stable: got dor=%b data=%h exp dor=1 data=%h", dor[0], data_out[0], e.data); end
    checks++; if (total != 1) begin
      errors++; $display("FAIL slow_strobes: got %0d exp 1", total); end
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
    got = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_rd[0] || dor[0]) got = 1;
    end
    checks++; if (got) begin
      errors++; $display("FAIL slow_park: got activity after enable low exp none"); end
  endtask

  task automatic test_wrap();
    bit got; int cyc, rds; logic [9:0] a; exp_t e;
    logic [31:0] pcs [2];
    pcs[0] = 32'hFFFF_FFFC; pcs[1] = 32'h0;
    do_reset();
    enable[1] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{pc: pcs[k], data: mem[pcs[k][11:2]]});
      wait_dor(1, 20, got, cyc, rds, a);
      e = sb.pop_front();
      checks++; if (!got || pc_out[1] !== e.pc || data_out[1] !== e.data) begin
        errors++; $display("FAIL wrap_fetch%0d: got pc=%h data=%h exp pc=%h data=%h",
                           k, pc_out[1], data_out[1], e.pc, e.data); end
      checks++; if (a !== e.pc[11:2]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h exp %h", k, a, e.pc[11:2]); end
      ack[1] = 1'b1;
      @(negedge clk);
      ack[1] = 1'b0;
    end
    checks++; if (pc_out[1] !== 32'h4) begin
      errors++; $display("FAIL wrap_pc_after: got %h exp 00000004", pc_out[1]); end
    enable[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit got, bad; int cyc, rds; logic [9:0] a;
    do_reset();
    enable[0] = 1'b1;
    wait_dor(0, 20, got, cyc, rds, a);
    checks++; if (!got) begin
      errors++; $display("FAIL rmid_present: got no DOR exp DOR=1"); end
    reset = 1'b1;
    enable[0] = 1'b0;
    @(negedge clk);
    checks++; if (dor[0] !== 1'b0 || pc_out[0] !== 32'h0 || data_out[0] !== 32'h0) begin
      errors++; $display("FAIL rmid_values: got dor=%b pc=%h data=%h exp 0/00000000/00000000",
                         dor[0], pc_out[0], data_out[0]); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (imem_rd[0] || dor[0]) bad = 1;
    end
    checks++; if (bad) begin
      errors++; $display("FAIL rmid_idle: got activity with enable low exp none"); end
  endtask

`ifdef IFETCH_REDIRECT_EN
  task automatic test_redirect();
    bit got, stale; int cyc; exp_t e;
    do_reset();
    lat[0] = 4;
    enable[0] = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (imem_rd[0]) got = 1;
    end
    @(negedge clk);
    redirect_valid[0] = 1'b1;
    redirect_pc[0]    = 32'h40;
    sb.push_back('{pc: 32'h40, data: mem[16]});
    @(negedge clk);
    redirect_valid[0] = 1'b0;
    got = 0; stale = 0; cyc = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (dor[0]) begin
        got = 1;
        if (data_out[0] === mem[0]) stale = 1;
      end
    end
    e = sb.pop_front();
    checks++; if (!got || stale) begin
      errors++; $display("FAIL redir_stale: got data=%h seen=%0b exp not %h", data_out[0], got, mem[0]); end
    checks++; if (data_out[0] !== e.data || pc_out[0] !== e.pc) begin
      errors++; $display("FAIL redir_fetch: got pc=%h data=%h exp pc=%h data=%h",
                         pc_out[0], data_out[0], e.pc, e.data); end
    enable[0] = 1'b0;
    ack[0] = 1'b1;
    @(negedge clk);
    ack[0] = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[0] = 32'h012A_4020;
    test_reset();
    test_basic();
    test_ack_held();
    test_slow_mem();
    test_wrap();
    test_reset_mid();
`ifdef IFETCH_REDIRECT_EN
    test_redirect();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
